// File: rtl/regfile_arbiter_if.sv
// Request/response bundle around the regfile arbiter: issue and commit
// handshakes, issue operand results, and the single regfile port.
// slave = arbiter side, master = requesters + regfile side.
interface regfile_arbiter_if #(
   parameter int REG_ID_BIT    = 5,
   parameter int ROB_WIDTH_BIT = 4
);
   // issue requester
   logic                     issue_valid;
   logic                     issue_ready;
   logic [REG_ID_BIT-1:0]    issue_rs1;
   logic [REG_ID_BIT-1:0]    issue_rs2;
   logic [REG_ID_BIT-1:0]    issue_rd;
   logic                     issue_rd_en;
   logic [ROB_WIDTH_BIT-1:0] issue_rob_id;
   logic                     issue_done;
   logic                     op1_busy;
   logic                     op2_busy;
   logic [31:0]              op1_value;
   logic [31:0]              op2_value;
   logic [ROB_WIDTH_BIT-1:0] op1_rob;
   logic [ROB_WIDTH_BIT-1:0] op2_rob;
   // commit requester
   logic                     commit_valid;
   logic                     commit_ready;
   logic [REG_ID_BIT-1:0]    commit_rd;
   logic [31:0]              commit_value;
   logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
   logic                     commit_done;
   // regfile port
   logic [REG_ID_BIT-1:0]    rf_reg_id;
   logic                     rf_row;
   logic                     rf_in_rob;
   logic [31:0]              rf_value;
   logic [ROB_WIDTH_BIT-1:0] rf_rob_id;
   logic                     rf_is_busy;
   logic [31:0]              rf_out_value;
   logic [ROB_WIDTH_BIT-1:0] rf_reorder;

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en, issue_rob_id,
      input  commit_valid, commit_rd, commit_value, commit_rob_id,
      input  rf_is_busy, rf_out_value, rf_reorder,
      output issue_ready, issue_done, op1_busy, op2_busy, op1_value, op2_value, op1_rob, op2_rob,
      output commit_ready, commit_done,
      output rf_reg_id, rf_row, rf_in_rob, rf_value, rf_rob_id
   );

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en, issue_rob_id,
      output commit_valid, commit_rd, commit_value, commit_rob_id,
      output rf_is_busy, rf_out_value, rf_reorder,
      input  issue_ready, issue_done, op1_busy, op2_busy, op1_value, op2_value, op1_rob, op2_rob,
      input  commit_ready, commit_done,
      input  rf_reg_id, rf_row, rf_in_rob, rf_value, rf_rob_id
   );
endinterface

// File: rtl/regfile_arbiter.sv
// Sequences the single-port register file between issue (read rs1, read rs2,
// rename rd) and commit (write value, re-rename if a newer producer exists).
// Owns the regfile port; every sequence is atomic and starts from IDLE.
module regfile_arbiter #(
   parameter int REG_ID_BIT    = 5,
   parameter int ROB_WIDTH_BIT = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   regfile_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, I_RS2, I_REN, C_CHK, C_RETAG} state_t;
   state_t state, state_nxt;

   logic                     last_commit;   // most recent grant went to commit
   logic [REG_ID_BIT-1:0]    rs1_q, rs2_q, rd_q, c_rd_q;
   logic                     rd_en_q;
   logic [ROB_WIDTH_BIT-1:0] rob_q, c_rob_q, retag_q;
   logic [31:0]              c_val_q;
   logic                     op1_busy_q;     // op1 held while rs2 is read
   logic [31:0]              op1_val_q;
   logic [ROB_WIDTH_BIT-1:0] op1_rob_q;
   logic                     o1_busy, o2_busy, issue_done_q, commit_done_q;
   logic [31:0]              o1_val, o2_val;
   logic [ROB_WIDTH_BIT-1:0] o1_rob, o2_rob;
   logic                     idle_go, grant_issue, grant_commit, retag_hit;

   // Round-robin: on a tie the requester served last yields.
   assign idle_go          = (state == IDLE) && rdy_in;
   assign bus.issue_ready  = idle_go && !(bus.commit_valid && !last_commit);
   assign bus.commit_ready = idle_go && !(bus.issue_valid && last_commit);
   assign grant_issue      = bus.issue_valid && bus.issue_ready;
   assign grant_commit     = bus.commit_valid && bus.commit_ready;
   // A newer rename of rd is in flight: the commit write must not drop it.
   assign retag_hit        = bus.rf_is_busy && (bus.rf_reorder != c_rob_q);

   assign bus.issue_done  = issue_done_q;
   assign bus.commit_done = commit_done_q;
   assign bus.op1_busy    = o1_busy;
   assign bus.op1_value   = o1_val;
   assign bus.op1_rob     = o1_rob;
   assign bus.op2_busy    = o2_busy;
   assign bus.op2_value   = o2_val;
   assign bus.op2_rob     = o2_rob;

   // State register; a paused cycle holds the sequence in place.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)      state <= IDLE;
      else if (rdy_in) state <= state_nxt;
   end

   // Next state and regfile port; idle port is a harmless read of x0.
   always_comb begin
      state_nxt     = state;
      bus.rf_reg_id = '0;
      bus.rf_row    = 1'b1;
      bus.rf_in_rob = 1'b0;
      bus.rf_value  = '0;
      bus.rf_rob_id = '0;
      case (state)
         IDLE: begin
            if (grant_issue) begin
               bus.rf_reg_id = bus.issue_rs1;
               state_nxt     = I_RS2;
            end else if (grant_commit && (bus.commit_rd != '0)) begin
               bus.rf_reg_id = bus.commit_rd;
               state_nxt     = C_CHK;
            end
         end
         I_RS2: begin
            bus.rf_reg_id = rs2_q;
            state_nxt     = I_REN;
         end
         I_REN: begin
            if (rd_en_q && (rd_q != '0)) begin
               bus.rf_row    = 1'b0;
               bus.rf_reg_id = rd_q;
               bus.rf_in_rob = 1'b1;
               bus.rf_rob_id = rob_q;
            end
            state_nxt = IDLE;
         end
         C_CHK: begin
            bus.rf_row    = 1'b0;
            bus.rf_reg_id = c_rd_q;
            bus.rf_value  = c_val_q;
            bus.rf_rob_id = c_rob_q;
            state_nxt     = retag_hit ? C_RETAG : IDLE;
         end
         C_RETAG: begin
            // keep the committed value but restore the newer producer tag
            bus.rf_row    = 1'b0;
            bus.rf_reg_id = c_rd_q;
            bus.rf_in_rob = 1'b1;
            bus.rf_value  = c_val_q;
            bus.rf_rob_id = retag_q;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latches, operand capture and done pulses.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_commit   <= 1'b0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         rd_en_q       <= 1'b0;
         rob_q         <= '0;
         c_rd_q        <= '0;
         c_val_q       <= '0;
         c_rob_q       <= '0;
         retag_q       <= '0;
         op1_busy_q    <= 1'b0;
         op1_val_q     <= '0;
         op1_rob_q     <= '0;
         o1_busy       <= 1'b0;
         o1_val        <= '0;
         o1_rob        <= '0;
         o2_busy       <= 1'b0;
         o2_val        <= '0;
         o2_rob        <= '0;
         issue_done_q  <= 1'b0;
         commit_done_q <= 1'b0;
      end else begin
         issue_done_q  <= 1'b0;
         commit_done_q <= 1'b0;
         if (rdy_in) begin
            if (grant_issue) begin
               rs1_q       <= bus.issue_rs1;
               rs2_q       <= bus.issue_rs2;
               rd_q        <= bus.issue_rd;
               rd_en_q     <= bus.issue_rd_en;
               rob_q       <= bus.issue_rob_id;
               last_commit <= 1'b0;
            end
            if (grant_commit) begin
               c_rd_q        <= bus.commit_rd;
               c_val_q       <= bus.commit_value;
               c_rob_q       <= bus.commit_rob_id;
               last_commit   <= 1'b1;
               commit_done_q <= (bus.commit_rd == '0);   // x0: nothing to write
            end
            case (state)
               I_RS2: begin
                  op1_busy_q <= (rs1_q != '0) && bus.rf_is_busy;
                  op1_val_q  <= (rs1_q != '0) ? bus.rf_out_value : 32'd0;
                  op1_rob_q  <= (rs1_q != '0) ? bus.rf_reorder : '0;
               end
               I_REN: begin
                  o1_busy      <= op1_busy_q;
                  o1_val       <= op1_val_q;
                  o1_rob       <= op1_rob_q;
                  o2_busy      <= (rs2_q != '0) && bus.rf_is_busy;
                  o2_val       <= (rs2_q != '0) ? bus.rf_out_value : 32'd0;
                  o2_rob       <= (rs2_q != '0) ? bus.rf_reorder : '0;
                  issue_done_q <= 1'b1;
               end
               C_CHK: begin
                  if (retag_hit) retag_q       <= bus.rf_reorder;
                  else           commit_done_q <= 1'b1;
               end
               C_RETAG: commit_done_q <= 1'b1;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: behavioural regfile, grant-time scoreboard for
// issue operands and commit results, directed steps in one initial block.
module tb_regfile_arbiter;
   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   always #5 clk_in = ~clk_in;

   regfile_arbiter_if #(.REG_ID_BIT(5), .ROB_WIDTH_BIT(4)) bus();
   regfile_arbiter #(.REG_ID_BIT(5), .ROB_WIDTH_BIT(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- regfile model (not reset by rst_in) ----------------
   logic        m_busy [32] = '{default: 1'b0};
   logic [31:0] m_val  [32] = '{default: 32'd0};
   logic [3:0]  m_tag  [32] = '{default: 4'd0};
   logic        pre_en = 1'b0;
   logic [4:0]  pre_id;
   logic [31:0] pre_val;

   always @(posedge clk_in) begin
      if (pre_en) begin
         m_busy[pre_id] <= 1'b0;
         m_val[pre_id]  <= pre_val;
      end else if (rdy_in) begin
         bus.rf_is_busy   <= m_busy[bus.rf_reg_id];
         bus.rf_out_value <= m_val[bus.rf_reg_id];
         bus.rf_reorder   <= m_tag[bus.rf_reg_id];
         if (!bus.rf_row && bus.rf_reg_id != 5'd0) begin
            m_busy[bus.rf_reg_id] <= bus.rf_in_rob;
            m_val[bus.rf_reg_id]  <= bus.rf_value;
            m_tag[bus.rf_reg_id]  <= bus.rf_rob_id;
         end
      end
   end

   // active (unpaused) cycle count, used for latency
   int acyc = 0;
   always @(posedge clk_in) if (rdy_in && !rst_in) acyc <= acyc + 1;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic b1; logic [31:0] v1; logic [3:0] t1;
      logic b2; logic [31:0] v2; logic [3:0] t2;
      int g;
   } iexp_t;
   typedef struct {
      logic [4:0] rd; logic b; logic [31:0] v; logic [3:0] t; int lat; int g;
   } cexp_t;

   iexp_t iq[$];
   cexp_t cq[$];
   logic  glog[$];          // 1 = commit grant, 0 = issue grant
   iexp_t ie_w, ie_r;
   cexp_t ce_w, ce_r;
   int    n_idone = 0, n_cdone = 0, last_c_lat = 0;
   logic        last_b1, last_b2;
   logic [31:0] last_v1;
   logic [3:0]  last_t1, last_t2;

   always @(negedge clk_in) begin
      if (rst_in) begin
         iq.delete();
         cq.delete();
      end else begin
         if (bus.issue_valid && bus.issue_ready) begin
            ie_w.b1 = (bus.issue_rs1 != 0) && m_busy[bus.issue_rs1];
            ie_w.v1 = (bus.issue_rs1 != 0) ? m_val[bus.issue_rs1] : 32'd0;
            ie_w.t1 = (bus.issue_rs1 != 0) ? m_tag[bus.issue_rs1] : 4'd0;
            ie_w.b2 = (bus.issue_rs2 != 0) && m_busy[bus.issue_rs2];
            ie_w.v2 = (bus.issue_rs2 != 0) ? m_val[bus.issue_rs2] : 32'd0;
            ie_w.t2 = (bus.issue_rs2 != 0) ? m_tag[bus.issue_rs2] : 4'd0;
            ie_w.g  = acyc;
            iq.push_back(ie_w);
            glog.push_back(1'b0);
         end
         if (bus.commit_valid && bus.commit_ready) begin
            ce_w.rd = bus.commit_rd;
            ce_w.v  = (bus.commit_rd == 0) ? 32'd0 : bus.commit_value;
            ce_w.g  = acyc;
            if (bus.commit_rd == 0) begin
               ce_w.b = 1'b0; ce_w.t = 4'd0; ce_w.lat = 1;
            end else if (m_busy[bus.commit_rd] && m_tag[bus.commit_rd] != bus.commit_rob_id) begin
               ce_w.b = 1'b1; ce_w.t = m_tag[bus.commit_rd]; ce_w.lat = 3;
            end else begin
               ce_w.b = 1'b0; ce_w.t = 4'd0; ce_w.lat = 2;
            end
            cq.push_back(ce_w);
            glog.push_back(1'b1);
         end
         if (bus.issue_done) begin
            n_idone++;
            check("issue_done_expected", 32'(iq.size() != 0), 32'd1);
            if (iq.size() != 0) begin
               ie_r = iq.pop_front();
               check("issue_latency", 32'(acyc - ie_r.g), 32'd3);
               check("op1_busy", 32'(bus.op1_busy), 32'(ie_r.b1));
               if (ie_r.b1) check("op1_rob", 32'(bus.op1_rob), 32'(ie_r.t1));
               else         check("op1_value", bus.op1_value, ie_r.v1);
               check("op2_busy", 32'(bus.op2_busy), 32'(ie_r.b2));
               if (ie_r.b2) check("op2_rob", 32'(bus.op2_rob), 32'(ie_r.t2));
               else         check("op2_value", bus.op2_value, ie_r.v2);
            end
            last_b1 = bus.op1_busy; last_v1 = bus.op1_value; last_t1 = bus.op1_rob;
            last_b2 = bus.op2_busy; last_t2 = bus.op2_rob;
         end
         if (bus.commit_done) begin
            n_cdone++;
            check("commit_done_expected", 32'(cq.size() != 0), 32'd1);
            if (cq.size() != 0) begin
               ce_r = cq.pop_front();
               last_c_lat = acyc - ce_r.g;
               check("commit_latency", 32'(last_c_lat), 32'(ce_r.lat));
               check("commit_rf_busy", 32'(m_busy[ce_r.rd]), 32'(ce_r.b));
               check("commit_rf_value", m_val[ce_r.rd], ce_r.v);
               if (ce_r.b) check("commit_rf_tag", 32'(m_tag[ce_r.rd]), 32'(ce_r.t));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic preload(input logic [4:0] id, input logic [31:0] v);
      pre_id = id; pre_val = v; pre_en = 1'b1;
      @(posedge clk_in); #1 pre_en = 1'b0;
   endtask

   task automatic do_issue(input logic [4:0] rs1, rs2, rd, input logic en, input logic [3:0] rob);
      int t;
      bus.issue_rs1 = rs1; bus.issue_rs2 = rs2; bus.issue_rd = rd;
      bus.issue_rd_en = en; bus.issue_rob_id = rob; bus.issue_valid = 1'b1;
      for (t = 0; t < 50; t++) begin
         @(negedge clk_in);
         if (bus.issue_ready) break;
      end
      check("issue_grant", 32'(bus.issue_ready), 32'd1);
      @(posedge clk_in); #1 bus.issue_valid = 1'b0;
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] v);
      int t;
      bus.commit_rd = rd; bus.commit_rob_id = rob; bus.commit_value = v;
      bus.commit_valid = 1'b1;
      for (t = 0; t < 50; t++) begin
         @(negedge clk_in);
         if (bus.commit_ready) break;
      end
      check("commit_grant", 32'(bus.commit_ready), 32'd1);
      @(posedge clk_in); #1 bus.commit_valid = 1'b0;
   endtask

   task automatic wait_idone(input string tag);
      int b = n_idone;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk_in); #2;
         if (n_idone != b) break;
      end
      check(tag, 32'(n_idone - b), 32'd1);
   endtask

   task automatic wait_cdone(input string tag);
      int b = n_cdone;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk_in); #2;
         if (n_cdone != b) break;
      end
      check(tag, 32'(n_cdone - b), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int base, n_same, n_i, n_c, b;
      rst_in = 1'b1; rdy_in = 1'b1;
      bus.issue_valid = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0; bus.issue_rd = '0;
      bus.issue_rd_en = 1'b0; bus.issue_rob_id = '0;
      bus.commit_valid = 1'b0; bus.commit_rd = '0; bus.commit_value = '0; bus.commit_rob_id = '0;
      preload(5'd5, 32'h1234);
      @(negedge clk_in);
      check("rst_issue_done", 32'(bus.issue_done), 32'd0);
      check("rst_commit_done", 32'(bus.commit_done), 32'd0);
      check("rst_op1_busy", 32'(bus.op1_busy), 32'd0);
      check("rst_op1_value", bus.op1_value, 32'd0);
      check("rst_op2_rob", 32'(bus.op2_rob), 32'd0);
      check("rst_rf_row", 32'(bus.rf_row), 32'd1);
      check("rst_rf_reg_id", 32'(bus.rf_reg_id), 32'd0);
      @(posedge clk_in); #1 rst_in = 1'b0;
      @(negedge clk_in);
      check("idle_issue_ready", 32'(bus.issue_ready), 32'd1);
      check("idle_commit_ready", 32'(bus.commit_ready), 32'd1);

      // 1: read x5, x0; rename x7 -> 3
      do_issue(5'd5, 5'd0, 5'd7, 1'b1, 4'd3);
      wait_idone("t1_done");
      check("t1_op1_value", last_v1, 32'h1234);
      check("t1_op1_busy", 32'(last_b1), 32'd0);
      check("t1_op2_busy", 32'(last_b2), 32'd0);
      check("t1_x7_busy", 32'(m_busy[7]), 32'd1);
      check("t1_x7_tag", 32'(m_tag[7]), 32'd3);

      // 2: matching commit clears busy
      do_commit(5'd7, 4'd3, 32'hDEAD);
      wait_cdone("t2_done");
      check("t2_latency", 32'(last_c_lat), 32'd2);
      check("t2_x7_busy", 32'(m_busy[7]), 32'd0);
      check("t2_x7_value", m_val[7], 32'hDEAD);

      // 3: newer rename survives a stale commit
      do_issue(5'd0, 5'd0, 5'd7, 1'b1, 4'd5);
      wait_idone("t3_rename_done");
      do_commit(5'd7, 4'd3, 32'hBEEF);
      wait_cdone("t3_done");
      check("t3_latency", 32'(last_c_lat), 32'd3);
      check("t3_x7_value", m_val[7], 32'hBEEF);
      check("t3_x7_busy", 32'(m_busy[7]), 32'd1);
      check("t3_x7_tag", 32'(m_tag[7]), 32'd5);

      // commit to x0: done next cycle, nothing written
      do_commit(5'd0, 4'd1, 32'hFFFF);
      wait_cdone("x0_commit_done");
      check("x0_commit_latency", 32'(last_c_lat), 32'd1);
      check("x0_value", m_val[0], 32'd0);

      // rd_en=0: no rename
      do_issue(5'd5, 5'd7, 5'd8, 1'b0, 4'd9);
      wait_idone("noren_done");
      check("noren_x8_busy", 32'(m_busy[8]), 32'd0);
      check("noren_op2_busy", 32'(last_b2), 32'd1);
      check("noren_op2_rob", 32'(last_t2), 32'd5);

      // 5: rs1 == rd sees the pre-rename state
      do_issue(5'd0, 5'd0, 5'd9, 1'b1, 4'd2);
      wait_idone("t5_setup_done");
      do_issue(5'd9, 5'd9, 5'd9, 1'b1, 4'd6);
      wait_idone("t5_done");
      check("t5_op1_busy", 32'(last_b1), 32'd1);
      check("t5_op1_rob", 32'(last_t1), 32'd2);
      check("t5_op2_rob", 32'(last_t2), 32'd2);
      check("t5_x9_tag", 32'(m_tag[9]), 32'd6);

      // 4: both held high for 20 cycles
      base = glog.size();
      bus.issue_rs1 = 5'd1; bus.issue_rs2 = 5'd2; bus.issue_rd = 5'd10;
      bus.issue_rd_en = 1'b1; bus.issue_rob_id = 4'd4;
      bus.commit_rd = 5'd10; bus.commit_rob_id = 4'd4; bus.commit_value = 32'h55;
      bus.issue_valid = 1'b1; bus.commit_valid = 1'b1;
      repeat (20) @(posedge clk_in);
      #1 bus.issue_valid = 1'b0; bus.commit_valid = 1'b0;
      repeat (10) @(posedge clk_in);
      n_same = 0; n_i = 0; n_c = 0;
      for (int i = base; i < glog.size(); i++) begin
         if (glog[i]) n_c++; else n_i++;
         if (i > base && glog[i] == glog[i-1]) n_same++;
      end
      check("t4_alternate", 32'(n_same), 32'd0);
      check("t4_issue_served", 32'(n_i >= 2), 32'd1);
      check("t4_commit_served", 32'(n_c >= 2), 32'd1);
      check("t4_drain_issue", 32'(iq.size()), 32'd0);
      check("t4_drain_commit", 32'(cq.size()), 32'd0);

      // 6: pause blocks handshakes, freezes I_RS2, reset aborts C_CHK
      #1 rdy_in = 1'b0; bus.commit_rd = 5'd12; bus.commit_valid = 1'b1;
      repeat (2) begin
         @(negedge clk_in);
         check("t6_paused_no_ready", 32'(bus.commit_ready), 32'd0);
      end
      @(posedge clk_in); #1 bus.commit_valid = 1'b0; rdy_in = 1'b1;
      do_issue(5'd5, 5'd6, 5'd11, 1'b1, 4'd7);
      rdy_in = 1'b0;
      b = n_idone;
      repeat (3) begin
         @(negedge clk_in);
         check("t6_freeze_rs2", 32'(bus.rf_reg_id), 32'd6);
         check("t6_freeze_no_done", 32'(bus.issue_done), 32'd0);
      end
      @(posedge clk_in); #1 rdy_in = 1'b1;
      check("t6_no_done_while_paused", 32'(n_idone - b), 32'd0);
      wait_idone("t6_issue_done");
      check("t6_op1_value", last_v1, 32'h1234);
      do_commit(5'd11, 4'd7, 32'h77);
      #2 rst_in = 1'b1;
      b = n_cdone;
      @(negedge clk_in);
      check("t6_rst_rf_row", 32'(bus.rf_row), 32'd1);
      @(posedge clk_in); #1 rst_in = 1'b0;
      repeat (5) @(negedge clk_in);
      check("t6_no_commit_done", 32'(n_cdone - b), 32'd0);
      check("t6_idle_after_rst", 32'(bus.issue_ready), 32'd1);
      check("t6_x11_unwritten_busy", 32'(m_busy[11]), 32'd1);
      check("t6_x11_unwritten_tag", 32'(m_tag[11]), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
